// File: rtl/asic_msg_schedule_if.sv
// Handshake bundle between the block buffer, the message schedule and the round core.
// master is the producer/consumer side, slave is the schedule generator.
interface asic_msg_schedule_if;
    logic [31:0] in_word;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] out_Wi;
    logic [5:0]  out_round_n;
    logic        out_valid;
    logic        in_next;
    logic        out_done;

    modport master (
        output in_word, in_valid, in_next,
        input  out_ready, out_Wi, out_round_n, out_valid, out_done
    );

    modport slave (
        input  in_word, in_valid, in_next,
        output out_ready, out_Wi, out_round_n, out_valid, out_done
    );
endinterface

// File: rtl/asic_msg_schedule.sv
// SHA-256 message schedule: loads sixteen words, then streams W[0]..W[63]
// one per consumer handshake using a 16-word sliding window.
module asic_msg_schedule (
    input  logic                  clk,
    input  logic                  rst,
    asic_msg_schedule_if.slave    bus
);

    typedef enum logic {StLoad, StRun} state_e;

    state_e      state_q;
    logic [3:0]  lcnt_q;
    logic [5:0]  rcnt_q;
    logic        done_q;
    logic [31:0] w_q [16];
    logic [31:0] w_new;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Next word past the window, W[rcnt+16]; also computed past round 48 where it is unused.
    assign w_new = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLoad;
            lcnt_q  <= 4'd0;
            rcnt_q  <= 6'd0;
            done_q  <= 1'b0;
            for (int j = 0; j < 16; j++) begin
                w_q[j] <= 32'd0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StLoad: begin
                    if (bus.in_valid) begin
                        w_q[lcnt_q] <= bus.in_word;
                        lcnt_q      <= lcnt_q + 4'd1;
                        if (lcnt_q == 4'd15) begin
                            state_q <= StRun;
                            rcnt_q  <= 6'd0;
                        end
                    end
                end
                StRun: begin
                    if (bus.in_next) begin
                        for (int j = 0; j < 15; j++) begin
                            w_q[j] <= w_q[j+1];
                        end
                        w_q[15] <= w_new;
                        rcnt_q  <= rcnt_q + 6'd1;
                        if (rcnt_q == 6'd63) begin
                            state_q <= StLoad;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign bus.out_ready   = (state_q == StLoad);
    assign bus.out_valid   = (state_q == StRun);
    assign bus.out_Wi      = w_q[0];
    assign bus.out_round_n = rcnt_q;
    assign bus.out_done    = done_q;

endmodule
